// File: rtl/param_sc_fifo.sv
// param_sc_fifo: parametrised single-clock FIFO with optional show-ahead read, almost flags and error pulses.
// Optional max_usedw_o peak-occupancy output enabled by SC_FIFO_WATERMARK_EN. Rev 1.0
`default_nettype none

module param_sc_fifo #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8,
    parameter int SHOWAHEAD  = 0,
    parameter int AFULL_LVL  = 2**ADDR_W - 2,
    parameter int AEMPTY_LVL = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] data_o,
    output logic [ADDR_W:0]   usedw_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_empty_o,
    output logic              almost_full_o,
`ifdef SC_FIFO_WATERMARK_EN
    output logic [ADDR_W:0]   max_usedw_o,
`endif
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int              c_DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W:0] c_DEPTH_CNT = c_DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] c_AFULL     = AFULL_LVL[ADDR_W:0];
    localparam logic [ADDR_W:0] c_AEMPTY    = AEMPTY_LVL[ADDR_W:0];
    localparam logic [ADDR_W:0] c_CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_PTR_ONE = ADDR_W'(1);

    if (AEMPTY_LVL < 0 || AEMPTY_LVL >= AFULL_LVL || AFULL_LVL > c_DEPTH) begin : g_param_err
        $error("param_sc_fifo: require 0 <= AEMPTY_LVL < AFULL_LVL <= 2**ADDR_W");
    end

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_usedw;
    logic [ADDR_W:0]   w_usedw_nxt;
    logic              r_empty;
    logic              r_full;
    logic              r_aempty;
    logic              r_afull;
    logic              r_ovf;
    logic              r_udf;
    logic              w_rd_acc;
    logic              w_wr_acc;

    // A write into a full FIFO is only legal when a read frees a slot on the same edge.
    always_comb begin
        w_rd_acc    = rd_en_i & ~r_empty;
        w_wr_acc    = wr_en_i & (~r_full | w_rd_acc);
        w_usedw_nxt = r_usedw;
        if (w_wr_acc && !w_rd_acc) begin
            w_usedw_nxt = r_usedw + c_CNT_ONE;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_usedw_nxt = r_usedw - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usedw  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_aempty <= 1'b1;
            r_afull  <= (c_AFULL == '0);
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_usedw  <= w_usedw_nxt;
            r_empty  <= (w_usedw_nxt == '0);
            r_full   <= (w_usedw_nxt == c_DEPTH_CNT);
            r_aempty <= (w_usedw_nxt <= c_AEMPTY);
            r_afull  <= (w_usedw_nxt >= c_AFULL);
            r_ovf    <= wr_en_i & ~w_wr_acc;
            r_udf    <= rd_en_i & ~w_rd_acc;
        end
    end

    // Show-ahead output is forced to zero while empty so reset clears it without a clock.
    if (SHOWAHEAD != 0) begin : g_showahead
        assign data_o = r_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_normal
        logic [DATA_W-1:0] r_data;
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_data <= '0;
            end else if (w_rd_acc) begin
                r_data <= r_mem[r_rd_ptr];
            end
        end
        assign data_o = r_data;
    end

`ifdef SC_FIFO_WATERMARK_EN
    logic [ADDR_W:0] r_max_usedw;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_max_usedw <= '0;
        end else if (w_usedw_nxt > r_max_usedw) begin
            r_max_usedw <= w_usedw_nxt;
        end
    end
    assign max_usedw_o = r_max_usedw;
`endif

    assign usedw_o        = r_usedw;
    assign empty_o        = r_empty;
    assign full_o         = r_full;
    assign almost_empty_o = r_aempty;
    assign almost_full_o  = r_afull;
    assign overflow_o     = r_ovf;
    assign underflow_o    = r_udf;

endmodule

`default_nettype wire

// File: tb/tb_param_sc_fifo.sv
// tb_param_sc_fifo: drives a normal-read and a show-ahead instance in lockstep against a queue model.
// Rev 1.0
`default_nettype none

module tb_param_sc_fifo;

    localparam int DEPTH = 32;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] din   = 8'h00;

    logic [7:0] data_n, data_s;
    logic [5:0] usedw_n, usedw_s;
    logic       empty_n, empty_s, full_n, full_s;
    logic       aempty_n, aempty_s, afull_n, afull_s;
    logic       ovf_n, ovf_s, udf_n, udf_s;
`ifdef SC_FIFO_WATERMARK_EN
    logic [5:0] max_n, max_s;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    param_sc_fifo #(.ADDR_W(5), .DATA_W(8), .SHOWAHEAD(0), .AFULL_LVL(30), .AEMPTY_LVL(1)) u_dut_n (
        .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr_en), .data_i(din), .rd_en_i(rd_en),
        .data_o(data_n), .usedw_o(usedw_n), .empty_o(empty_n), .full_o(full_n),
        .almost_empty_o(aempty_n), .almost_full_o(afull_n),
`ifdef SC_FIFO_WATERMARK_EN
        .max_usedw_o(max_n),
`endif
        .overflow_o(ovf_n), .underflow_o(udf_n)
    );

    param_sc_fifo #(.ADDR_W(5), .DATA_W(8), .SHOWAHEAD(1), .AFULL_LVL(30), .AEMPTY_LVL(1)) u_dut_s (
        .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr_en), .data_i(din), .rd_en_i(rd_en),
        .data_o(data_s), .usedw_o(usedw_s), .empty_o(empty_s), .full_o(full_s),
        .almost_empty_o(aempty_s), .almost_full_o(afull_s),
`ifdef SC_FIFO_WATERMARK_EN
        .max_usedw_o(max_s),
`endif
        .overflow_o(ovf_s), .underflow_o(udf_s)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain queue, updated on each clock edge from the sampled requests.
    logic [7:0] q[$];
    logic [7:0] m_data_n = 8'h00;
    bit         m_ovf    = 1'b0;
    bit         m_udf    = 1'b0;
    int         m_peak   = 0;
    bit         rd_ok, wr_ok;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_data_n = 8'h00;
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
            m_peak   = 0;
        end else begin
            rd_ok = rd_en && (q.size() != 0);
            wr_ok = wr_en && ((q.size() < DEPTH) || rd_ok);
            if (rd_ok) m_data_n = q.pop_front();
            if (wr_ok) q.push_back(din);
            m_ovf = wr_en && !wr_ok;
            m_udf = rd_en && !rd_ok;
            if (q.size() > m_peak) m_peak = q.size();
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("usedw_n",  usedw_n,  q.size());
            chk("usedw_s",  usedw_s,  q.size());
            chk("empty_n",  empty_n,  q.size() == 0);
            chk("empty_s",  empty_s,  q.size() == 0);
            chk("full_n",   full_n,   q.size() == DEPTH);
            chk("full_s",   full_s,   q.size() == DEPTH);
            chk("aempty_n", aempty_n, q.size() <= 1);
            chk("aempty_s", aempty_s, q.size() <= 1);
            chk("afull_n",  afull_n,  q.size() >= 30);
            chk("afull_s",  afull_s,  q.size() >= 30);
            chk("ovf_n",    ovf_n,    m_ovf);
            chk("ovf_s",    ovf_s,    m_ovf);
            chk("udf_n",    udf_n,    m_udf);
            chk("udf_s",    udf_s,    m_udf);
            chk("data_n",   data_n,   m_data_n);
            if (q.size() != 0) chk("data_s", data_s, q[0]);
`ifdef SC_FIFO_WATERMARK_EN
            chk("max_n", max_n, m_peak);
            chk("max_s", max_s, m_peak);
`endif
        end
    end

    task automatic step(input bit w, input bit r, input logic [7:0] d);
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_usedw",  usedw_n,  0);
        chk("rst_empty",  empty_s,  1);
        chk("rst_aempty", aempty_n, 1);
        chk("rst_full",   full_n,   0);
        chk("rst_afull",  afull_s,  0);
        chk("rst_data_n", data_n,   0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full; almost_full rises exactly at 30.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 8'($urandom));
            if (i == 28) chk("afull_at29", afull_n, 0);
            if (i == 29) chk("afull_at30", afull_n, 1);
        end
        chk("fill_usedw", usedw_n, 32);
        chk("fill_full",  full_s,  1);

        step(1'b1, 1'b0, 8'hEE);
        chk("ovf_pulse",  ovf_n,   1);
        chk("ovf_usedw",  usedw_s, 32);
        step(1'b0, 1'b0, 8'h00);
        chk("ovf_clear",  ovf_s,   0);

        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 8'($urandom));
        end
        chk("simul_usedw", usedw_n, 32);

        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 8'h00);
            if (i == 1)  chk("afull_at30_dn", afull_n,  1);
            if (i == 2)  chk("afull_at29_dn", afull_n,  0);
            if (i == 29) chk("aempty_at2",    aempty_s, 0);
            if (i == 30) chk("aempty_at1",    aempty_s, 1);
        end
        chk("drain_empty", empty_n, 1);
        chk("drain_usedw", usedw_s, 0);

        step(1'b0, 1'b1, 8'h00);
        chk("udf_pulse", udf_n,   1);
        chk("udf_usedw", usedw_n, 0);
        step(1'b0, 1'b0, 8'h00);
        chk("udf_clear", udf_s,   0);

        step(1'b1, 1'b1, 8'h5A);
        chk("we_usedw", usedw_n, 1);
        chk("we_udf",   udf_s,   1);
        step(1'b0, 1'b1, 8'h00);
        chk("we_data_n", data_n, 8'h5A);

        step(1'b1, 1'b0, 8'hA5);
        chk("sa_empty", empty_s, 0);
        chk("sa_data",  data_s,  8'hA5);
        step(1'b0, 1'b1, 8'h00);
        chk("sa_empty_after", empty_s, 1);

        for (int i = 0; i < 100; i++) begin
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45, 8'($urandom));
        end

        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(i + 16));
`ifdef SC_FIFO_WATERMARK_EN
        chk("wm_peak", max_n, 32);
`endif
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_usedw",  usedw_n, 0);
        chk("mrst_empty",  empty_s, 1);
        chk("mrst_data_n", data_n,  0);
        chk("mrst_data_s", data_s,  0);
`ifdef SC_FIFO_WATERMARK_EN
        chk("mrst_wm", max_s, 0);
`endif
        step(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        wr_en = 1'b1;
        rd_en = 1'b0;
        din   = 8'h3C;
        @(posedge clk);
        #1;
        chk("post_rst_usedw", usedw_n, 1);
        chk("post_rst_data",  data_s,  8'h3C);
        step(1'b0, 1'b0, 8'h00);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/param_sc_fifo.md
Name: param_sc_fifo

Overview:
Parametrised single-clock FIFO, successor to the team's generic single-clock FIFO.
- Adds a selectable show-ahead (first-word-fall-through) read mode, programmable almost-full and almost-empty flags, and overflow/underflow error pulses.
- Intended as the default buffering element between streaming blocks in one clock domain.

Parameters:
ADDR_W, 5, address width; depth = 2**ADDR_W words
DATA_W, 8, data word width in bits
SHOWAHEAD, 0, 0 = normal registered read; 1 = show-ahead read
AFULL_LVL, 2**ADDR_W-2, almost_full_o asserted when usedw_o >= AFULL_LVL
AEMPTY_LVL, 1, almost_empty_o asserted when usedw_o <= AEMPTY_LVL

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
wr_en_i  in  1  write request
data_i  in  DATA_W  write data
rd_en_i  in  1  read request (normal mode) / pop acknowledge (show-ahead mode)
data_o  out  DATA_W  read data
usedw_o  out  ADDR_W+1  number of stored words, 0..2**ADDR_W
empty_o  out  1  usedw_o == 0
full_o  out  1  usedw_o == 2**ADDR_W
almost_empty_o  out  1  usedw_o <= AEMPTY_LVL
almost_full_o  out  1  usedw_o >= AFULL_LVL
overflow_o  out  1  1-cycle error pulse
underflow_o  out  1  1-cycle error pulse

Behaviour:
Reset:
- rst_n_i low clears pointers, usedw_o and data_o to 0 immediately.
- During reset: empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0 (unless AFULL_LVL==0), overflow_o=0, underflow_o=0.
- Reset mid-operation discards all contents. First accepted write is allowed on the first rising edge after rst_n_i is released.

Accept rules, evaluated on registered state:
- rd_acc = rd_en_i & !empty_o.
- wr_acc = wr_en_i & (!full_o | rd_acc).
- Write while full is accepted only if a read is accepted in the same cycle.
- Read while empty is never accepted, even with a simultaneous write.

Count and flags:
- usedw_o += wr_acc - rd_acc each edge; with both accepted, usedw_o is unchanged.
- All flags are registered and computed from the next count, so they change on the same edge as usedw_o.
- Pointers are ADDR_W bits wide and wrap modulo 2**ADDR_W with no gap.

SHOWAHEAD=0:
- Accepted read loads data_o with the head word on that edge, i.e. valid the cycle after rd_en_i is sampled.
- data_o holds its value when no read is accepted.

SHOWAHEAD=1:
- data_o = mem[rd_ptr], combinational from the registered pointer. It is valid whenever empty_o=0.
- The first write into an empty FIFO is visible on data_o and empty_o falls on the same edge.
- rd_acc advances the pointer; the next word is presented after that edge.
- data_o is don't-care while empty_o=1.

Errors:
- overflow_o pulses high for one cycle after an edge where wr_en_i=1 and the write is not accepted.
- underflow_o pulses likewise for rd_en_i=1 with the read not accepted.
- FIFO contents and count are unaffected by rejected requests.

Parameter check:
- Elaboration error unless 0 <= AEMPTY_LVL < AFULL_LVL <= 2**ADDR_W.

Optional Feature:
Macro: SC_FIFO_WATERMARK_EN
- Defined: adds output max_usedw_o (ADDR_W+1 bits).
  - Registered peak of usedw_o since reset; updates on the same edge as usedw_o.
  - Reset to 0; never decreases except on reset.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
1. Fill/drain: defaults, write 32 random bytes, then 32 reads in each SHOWAHEAD mode -> full_o=1 and usedw_o=32 after the 32nd write; read order matches write order; empty_o=1 and usedw_o=0 at the end.
2. Overflow and underflow:
   - Write a 33rd word while full with rd_en_i=0 -> overflow_o one-cycle pulse, usedw_o stays 32, data unchanged.
   - Read while empty -> underflow_o pulse, usedw_o stays 0.
3. Simultaneous read/write:
   - At full (32), wr_en_i=rd_en_i=1 for 10 cycles -> usedw_o stays 32 and data order is preserved.
   - At empty, same stimulus for 1 cycle -> write accepted, read rejected, usedw_o=1, underflow_o pulses.
4. Thresholds with AFULL_LVL=30, AEMPTY_LVL=1:
   - almost_full_o rises on the edge where usedw_o becomes 30 and falls when it returns to 29.
   - almost_empty_o is 1 at usedw_o 0..1 and 0 at 2.
5. Show-ahead latency: SHOWAHEAD=1, single write of 0xA5 into empty -> empty_o=0 and data_o=0xA5 after that edge; one rd_en_i pulse -> empty_o=1 next edge.
6. Wrap and reset:
   - Run 100 cycles of random push/pop across pointer wrap against a reference queue -> no mismatch.
   - Assert rst_n_i mid-stream -> usedw_o=0, empty_o=1 and data_o=0 immediately, without waiting for a clock edge.
   - With SC_FIFO_WATERMARK_EN, max_usedw_o equals the peak count and clears to 0 on reset.
